// File: rtl/x86_pkg.sv
// Shared definitions for the x86-style ALU execute stage: opcode encodings,
// FSM states, flag bit positions and the single-cycle ALU function.
package x86_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_CMP = 3'b101,
    OP_MUL = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MUL,
    ST_WB
  } state_e;

  // Bit positions inside the {OF,SF,ZF,CF} flags vector
  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] flags;
  } alu_out_t;

  function automatic alu_out_t alu_compute(input op_e code, input logic [7:0] a, input logic [7:0] b);
    alu_out_t   o;
    logic [8:0] wide;
    o.result = b;
    o.flags  = '0;
    wide     = '0;
    case (code)
      OP_ADD: begin
        wide                = {1'b0, a} + {1'b0, b};
        o.result            = wide[7:0];
        o.flags[FLAG_CF]    = wide[8];
        o.flags[FLAG_OF]    = (a[7] == b[7]) && (o.result[7] != a[7]);
      end
      OP_SUB, OP_CMP: begin
        // Bit 8 of the 9-bit difference is the borrow out
        wide                = {1'b0, a} - {1'b0, b};
        o.result            = wide[7:0];
        o.flags[FLAG_CF]    = wide[8];
        o.flags[FLAG_OF]    = (a[7] != b[7]) && (o.result[7] != a[7]);
      end
      OP_AND:  o.result = a & b;
      OP_OR:   o.result = a | b;
      OP_XOR:  o.result = a ^ b;
      default: o.result = b;
    endcase
    o.flags[FLAG_ZF] = (o.result == 8'd0);
    o.flags[FLAG_SF] = o.result[7];
    return o;
  endfunction

endpackage

// File: rtl/seq_mul8.sv
// 8x8 shift-add multiplier, one multiplier bit per clock; done flags the
// cycle whose edge performs the eighth iteration, with product already final.
module seq_mul8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  count;

  // Accumulator plus this cycle's partial product; equals acc once idle
  assign product = acc + (mplier[0] ? mcand : 16'd0);
  assign done    = busy && (count == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {8'd0, a};
      mplier <= b;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 3'd1;
      if (count == 3'd7) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Multi-cycle ALU execute stage: reads two registers, executes (or runs the
// sequential multiplier), then writes back the result and updates flags.
module alu_exec_stage
  import x86_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [2:0] op_dst,
  input  logic [2:0] op_src,
  input  logic [7:0] op_imm,
  input  logic       op_use_imm,
  output logic [2:0] read_addr1,
  output logic [2:0] read_addr2,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  output logic [2:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_enable,
  output logic [3:0] flags,
  output logic       done,
  output logic       err
);

  state_e     state;
  op_e        code_q;
  logic [2:0] dst_q;
  logic [7:0] imm_q;
  logic       use_imm_q;
  logic       bad_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] operand_b;
  logic       mul_start;
  logic [15:0] mul_product;
  logic       mul_busy;
  logic       mul_done;
  alu_out_t   wb_out;

  assign operand_b = use_imm_q ? imm_q : read_data2;
  assign mul_start = (state == ST_READ) && (code_q == OP_MUL);

  seq_mul8 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (read_data1),
    .b       (operand_b),
    .product (mul_product),
    .busy    (mul_busy),
    .done    (mul_done)
  );

  // Writeback value: ALU result in EXEC, multiplier low byte in MUL
  always_comb begin
    wb_out = alu_compute(code_q, a_q, b_q);
    if (state == ST_MUL) begin
      wb_out.result           = mul_product[7:0];
      wb_out.flags            = '0;
      wb_out.flags[FLAG_CF]   = |mul_product[15:8];
      wb_out.flags[FLAG_OF]   = |mul_product[15:8];
      wb_out.flags[FLAG_ZF]   = (mul_product[7:0] == 8'd0);
      wb_out.flags[FLAG_SF]   = mul_product[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      op_ready     <= 1'b1;
      code_q       <= OP_ADD;
      dst_q        <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      bad_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      read_addr1   <= '0;
      read_addr2   <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      flags        <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            code_q     <= op_e'(op_code);
            dst_q      <= op_dst;
            imm_q      <= op_imm;
            use_imm_q  <= op_use_imm;
            bad_q      <= op_dst[2] || (op_src[2] && !op_use_imm);
            read_addr1 <= op_dst;
            read_addr2 <= op_src;
            op_ready   <= 1'b0;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= read_data1;
          b_q   <= operand_b;
          state <= (code_q == OP_MUL) ? ST_MUL : ST_EXEC;
        end
        ST_EXEC, ST_MUL: begin
          if ((state == ST_EXEC) || (mul_busy && mul_done)) begin
            write_addr   <= dst_q;
            write_data   <= wb_out.result;
            write_enable <= !bad_q && (code_q != OP_CMP);
            done         <= 1'b1;
            err          <= bad_q;
            if (!bad_q && (code_q != OP_MOV)) flags <= wb_out.flags;
            state        <= ST_WB;
          end
        end
        ST_WB: begin
          write_enable <= 1'b0;
          done         <= 1'b0;
          err          <= 1'b0;
          op_ready     <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed scoreboard bench for alu_exec_stage with a behavioural register
// file; expected writes and flags come from an independent integer model.
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_code = '0;
  logic [2:0] op_dst = '0;
  logic [2:0] op_src = '0;
  logic [7:0] op_imm = '0;
  logic       op_use_imm = 1'b0;
  logic [2:0] read_addr1;
  logic [2:0] read_addr2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic       write_enable;
  logic [3:0] flags;
  logic       done;
  logic       err;

  logic [7:0] rf [0:7] = '{8'h7F, 8'h01, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_rf [0:7] = '{8'h7F, 8'h01, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] exp_flags = 4'b0000;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_first;
  int n_second;
  bit saw_activity;

  typedef struct {
    int         n;
    int         lat;
    logic [2:0] addr;
    logic [7:0] data;
    logic       we;
    logic       err;
    logic [3:0] flg;
  } exp_t;

  exp_t sb [$];

  alu_exec_stage dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_dst       (op_dst),
    .op_src       (op_src),
    .op_imm       (op_imm),
    .op_use_imm   (op_use_imm),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .flags        (flags),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  always @(posedge clk) begin
    if (write_enable) rf[write_addr] <= write_data;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer arithmetic, range checks for overflow
  function automatic void model(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] fin, output logic [7:0] res, output logic [3:0] fout);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb_v = int'($signed(b));
    int r = 0;
    int sr = 0;
    logic cf = 1'b0;
    logic of = 1'b0;
    case (code)
      3'd0: begin r = ua + ub; sr = sa + sb_v; cf = (r > 255); of = (sr > 127) || (sr < -128); end
      3'd1, 3'd5: begin r = ua - ub; sr = sa - sb_v; cf = (ua < ub); of = (sr > 127) || (sr < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd6: begin r = ua * ub; cf = (r > 255); of = cf; end
      default: r = ub;
    endcase
    res  = r[7:0];
    fout = (code == 3'd7) ? fin : {of, res[7], (res == 8'd0), cf};
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] code, input logic [2:0] dst,
                               input logic [2:0] src, input logic [7:0] imm, input logic use_imm,
                               input bit hold, input bit track, output int n);
    int waited = 0;
    exp_t e;
    logic [7:0] res;
    logic [3:0] fl;
    logic [7:0] bval;
    logic invalid;
    while (!op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_accept: observed op_ready=0 expected op_ready=1 within 50 cycles", tag);
    end
    op_valid   = 1'b1;
    op_code    = code;
    op_dst     = dst;
    op_src     = src;
    op_imm     = imm;
    op_use_imm = use_imm;
    n = cyc + 1;
    if (track) begin
      invalid = dst[2] || (src[2] && !use_imm);
      bval = use_imm ? imm : exp_rf[src];
      model(code, exp_rf[dst], bval, exp_flags, res, fl);
      e.n    = n;
      e.lat  = (code == 3'd6) ? 10 : 3;
      e.addr = dst;
      e.data = res;
      e.we   = !invalid && (code != 3'd5);
      e.err  = invalid;
      e.flg  = invalid ? exp_flags : fl;
      sb.push_back(e);
      if (e.we) exp_rf[dst] = res;
      exp_flags = e.flg;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) op_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int waited = 0;
    exp_t e;
    while (!done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!done || sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_done: observed done=%0b queued=%0d expected done=1 with a queued result",
             tag, done, sb.size());
      if (sb.size() != 0) e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    compare({tag, "_lat"}, 16'(cyc + 1 - e.n), 16'(e.lat));
    compare({tag, "_we"}, 16'(write_enable), 16'(e.we));
    compare({tag, "_err"}, 16'(err), 16'(e.err));
    compare({tag, "_waddr"}, 16'(write_addr), 16'(e.addr));
    if (e.we) compare({tag, "_wdata"}, 16'(write_data), 16'(e.data));
    compare({tag, "_flags"}, 16'(flags), 16'(e.flg));
    @(negedge clk);
    compare({tag, "_pulse"}, 16'({done, write_enable, err}), 16'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    compare("rst_ready", 16'(op_ready), 16'(1));
    compare("rst_outs", 16'({done, err, write_enable}), 16'(0));
    compare("rst_flags", 16'(flags), 16'(0));
    compare("rst_raddr", 16'({read_addr1, read_addr2}), 16'(0));
    compare("rst_waddr", 16'(write_addr), 16'(0));
    compare("rst_wdata", 16'(write_data), 16'(0));
    rst = 1'b1;
    @(negedge clk);

    applyStimulus("add", 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("add");
    applyStimulus("mov5", 3'd7, 3'd0, 3'd0, 8'h05, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("mov5");
    applyStimulus("subimm", 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("subimm");
    applyStimulus("cmp", 3'd5, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("cmp");
    applyStimulus("mul", 3'd6, 3'd2, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("mul");
    applyStimulus("baddst", 3'd0, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("baddst");
    applyStimulus("badsrc", 3'd3, 3'd0, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("badsrc");
    applyStimulus("xorimm", 3'd4, 3'd0, 3'd6, 8'h3C, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("xorimm");
    applyStimulus("and", 3'd2, 3'd3, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("and");
    applyStimulus("orimm", 3'd3, 3'd1, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("orimm");

    // op_valid stays high across the whole MOV; the next op must wait for IDLE
    applyStimulus("movhold", 3'd7, 3'd0, 3'd0, 8'hAA, 1'b1, 1'b1, 1'b1, n_first);
    compare("hold_ready_n1", 16'(op_ready), 16'(0));
    @(negedge clk);
    compare("hold_ready_n2", 16'(op_ready), 16'(0));
    @(negedge clk);
    compare("hold_ready_n3", 16'(op_ready), 16'(0));
    checkOutput("movhold");
    applyStimulus("movnext", 3'd7, 3'd1, 3'd0, 8'h55, 1'b1, 1'b0, 1'b1, n_second);
    compare("hold_next_accept", 16'(n_second - n_first), 16'(4));
    checkOutput("movnext");

    applyStimulus("mulrst", 3'd6, 3'd0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, n_first);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_flags = 4'b0000;
    compare("mulrst_ready", 16'(op_ready), 16'(1));
    compare("mulrst_outs", 16'({done, err, write_enable}), 16'(0));
    compare("mulrst_flags", 16'(flags), 16'(0));
    @(negedge clk);
    rst = 1'b1;
    saw_activity = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || write_enable) saw_activity = 1'b1;
    end
    compare("mulrst_quiet", 16'(saw_activity), 16'(0));

    applyStimulus("addcarry", 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, n_first);
    checkOutput("addcarry");
    applyStimulus("subborrow", 3'd1, 3'd1, 3'd0, 8'h56, 1'b1, 1'b0, 1'b1, n_first);
    checkOutput("subborrow");

    for (int i = 0; i < 4; i++) compare($sformatf("rf%0d", i), 16'(rf[i]), 16'(exp_rf[i]));
    compare("sb_empty", 16'(sb.size()), 16'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
